timer_seq_ctrl: RTL
===================

TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 SHALL have parameter POLL_GAP, default 16: pclk cycles between TSR polls.
REQ-002 SHALL have parameter POLL_MAX, default 255: max TSR polls before timeout.
REQ-003 SHALL have port pclk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port preset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request to run a sequence; sampled only in IDLE.
REQ-006 SHALL have port cfg_tdr  in  8  start value for TDR.
REQ-007 SHALL have port cfg_updw  in  1  0 = count up (expect OVF), 1 = count down (expect UDF).
REQ-008 SHALL have port cfg_cks  in  2  clock-select code, copied to TCR[1:0].
REQ-009 SHALL have ports psel, penable, pwrite  out  1 each  APB master control.
REQ-010 SHALL have ports paddr, pwdata  out  8 each  APB address and write data.
REQ-011 SHALL have ports prdata  in  8, pready  in  1, pslverr  in  1  APB slave response.
REQ-012 SHALL have port busy  out  1  high from accepted start until done.
REQ-013 SHALL have port done  out  1  one-cycle pulse at sequence end.
REQ-014 SHALL have port status  out  2  {timeout, flag_ok}, valid with done and held until next start.
REQ-015 SHALL have port err  out  1  sticky, set by pslverr; cleared by the next accepted start.

Function
REQ-016 SHALL use register map TDR=0x00, TCR=0x01, TSR=0x02; TCR[7]=load, TCR[5]=updw, TCR[4]=en, TCR[1:0]=cks; TSR[0]=OVF, TSR[1]=UDF.
REQ-017 SHALL perform every access in two phases: SETUP (psel=1, penable=0) for one cycle, then ACCESS (psel=1, penable=1) held until pready=1; psel/penable drop the cycle after pready.
REQ-018 SHALL keep paddr, pwrite and pwdata stable from SETUP through the pready cycle.
REQ-019 SHALL capture prdata on reads in the cycle pready=1.
REQ-020 SHALL latch cfg_* on the start cycle; later cfg_* changes have no effect on the running sequence.
REQ-021 SHALL use states IDLE, WR_TDR, RD_TSR0, CLR_TSR0, WR_LOAD, WR_RUN, WAIT, POLL, WR_STOP, CLR_TSR, DONE.
REQ-022 SHALL go IDLE->WR_TDR on start and write TDR=cfg_tdr.
REQ-023 SHALL go WR_TDR->RD_TSR0 and read TSR; if the read value is nonzero, go to CLR_TSR0 and write TSR=0x00, otherwise skip to WR_LOAD.
REQ-024 SHALL in WR_LOAD write TCR=0x80, then in WR_RUN write TCR={0,0,updw,1,0,0,cks}; for example updw=0 and cks=01 gives 0x11.
REQ-025 SHALL in WAIT count POLL_GAP pclk cycles, then go to POLL and read TSR.
REQ-026 SHALL set flag_ok in POLL when TSR bit (updw ? 1 : 0) is 1, then go to WR_STOP; otherwise increment the poll counter and return to WAIT.
REQ-027 SHALL set timeout when the poll counter reaches POLL_MAX without the expected flag, then go to WR_STOP.
REQ-028 SHALL in WR_STOP write TCR=0x00, in CLR_TSR write TSR=0x00, then go to DONE.
REQ-029 SHALL in DONE pulse done for one cycle and return to IDLE; busy is low in IDLE only.
REQ-030 SHALL on pslverr=1 in any pready cycle set err and continue the sequence unchanged.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL NOT treat the unexpected flag bit (e.g. UDF during an up-count) as success; polling continues.
REQ-033 SHALL use an 8-bit poll counter with no wrap-around; it saturates at POLL_MAX.

Reset
REQ-034 SHALL on preset=1 at a clock edge enter IDLE and set psel, penable, pwrite, done, busy, err to 0, status to 2'b00, and paddr, pwdata and counters to 0, including mid-transfer; an in-flight APB access is abandoned.

Verification
REQ-035 Up-count: start with cfg_tdr=0x79, updw=0, cks=01, timer model attached -> writes 0x79@0x00, 0x80@0x01, 0x11@0x01; OVF seen; done with status=2'b01; final TSR=0x00.
REQ-036 Down-count: updw=1, cks=00 -> run write 0x30@0x01; done with status=01 only after TSR[1]=1; TSR[0]=1 alone is not accepted.
REQ-037 Stale status: TSR preset to 0x01 before start -> CLR_TSR0 write 0x00@0x02 occurs before WR_LOAD.
REQ-038 Timeout: slave never sets flags, POLL_MAX=4 -> exactly 4 TSR polls, then TCR=0x00 and TSR=0x00 written; done with status=2'b10.
REQ-039 Wait states: pready held low 3 cycles on each access -> penable held and addr/data stable; sequence result is unchanged.
REQ-040 pslverr on the WR_TDR access, plus preset asserted in a later WAIT state -> err=1 until reset; after reset all outputs are 0 and psel is low the next cycle.

Source files
------------

// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: APB master that programs a timer peripheral, starts it,
// polls its status register for the expected overflow/underflow flag and
// then stops and cleans it up, reporting the outcome on status/done.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; only state with busy low
// WR_TDR   | write start value to TDR
// RD_TSR0  | read TSR to detect stale flags from a previous run
// CLR_TSR0 | clear stale TSR flags
// WR_LOAD  | write TCR load bit
// WR_RUN   | write TCR enable with direction and clock select
// WAIT     | gap down-counter between polls
// POLL     | read TSR and test the expected flag
// WR_STOP  | write TCR = 0 to stop the timer
// CLR_TSR  | clear TSR flags
// DONE     | one-cycle done pulse, then back to IDLE
//
// Every bus access runs SETUP -> ACCESS (held until pready) -> GAP. The GAP
// cycle drops psel/penable and is where the FSM moves on, so any decision
// based on read data uses the value already captured into rd_q.

module timer_seq_ctrl #(
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 255
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       start,
    input  logic [7:0] cfg_tdr,
    input  logic       cfg_updw,
    input  logic [1:0] cfg_cks,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic       err
);

    localparam logic [7:0]  ADDR_TDR   = 8'h00;
    localparam logic [7:0]  ADDR_TCR   = 8'h01;
    localparam logic [7:0]  ADDR_TSR   = 8'h02;
    localparam logic [7:0]  TCR_LOAD   = 8'h80;
    localparam logic [7:0]  TCR_STOP   = 8'h00;
    localparam logic [7:0]  TSR_CLEAR  = 8'h00;
    localparam logic [15:0] GAP_LOAD   = 16'(POLL_GAP - 1);
    localparam logic [7:0]  POLL_LIMIT = 8'(POLL_MAX);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_TDR,
        S_RD_TSR0,
        S_CLR_TSR0,
        S_WR_LOAD,
        S_WR_RUN,
        S_WAIT,
        S_POLL,
        S_WR_STOP,
        S_CLR_TSR,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_ACCESS,
        PH_GAP
    } phase_t;

    state_t      state;
    state_t      state_n;
    state_t      after_access;
    phase_t      phase;
    phase_t      phase_n;

    logic        is_access;
    logic        acc_write;
    logic [7:0]  acc_addr;
    logic [7:0]  acc_wdata;
    logic        xfer_done;

    logic [7:0]  tdr_q;
    logic        updw_q;
    logic [1:0]  cks_q;
    logic [7:0]  rd_q;
    logic [15:0] gap_cnt;
    logic [7:0]  poll_cnt;
    logic [7:0]  poll_inc;
    logic        poll_last;
    logic        poll_step;
    logic        flag_hit;
    logic        flag_ok;
    logic        timeout;
    logic        err_q;
    logic        start_acc;
    logic        enter_wait;

    assign start_acc  = (state == S_IDLE) && start;
    assign xfer_done  = is_access && (phase == PH_ACCESS) && pready;
    assign poll_step  = (state == S_POLL) && (phase == PH_GAP);
    assign flag_hit   = updw_q ? rd_q[1] : rd_q[0];
    assign poll_inc   = (poll_cnt >= POLL_LIMIT) ? poll_cnt : poll_cnt + 8'd1;
    assign poll_last  = (poll_inc >= POLL_LIMIT);
    assign enter_wait = (state_n == S_WAIT) && (state != S_WAIT);

    // Per-state bus access: address, direction, write data and successor.
    always_comb begin
        is_access    = 1'b1;
        acc_write    = 1'b1;
        acc_addr     = ADDR_TSR;
        acc_wdata    = TSR_CLEAR;
        after_access = state;
        case (state)
            S_WR_TDR: begin
                acc_addr     = ADDR_TDR;
                acc_wdata    = tdr_q;
                after_access = S_RD_TSR0;
            end
            S_RD_TSR0: begin
                acc_write    = 1'b0;
                after_access = (rd_q != 8'h00) ? S_CLR_TSR0 : S_WR_LOAD;
            end
            S_CLR_TSR0: begin
                after_access = S_WR_LOAD;
            end
            S_WR_LOAD: begin
                acc_addr     = ADDR_TCR;
                acc_wdata    = TCR_LOAD;
                after_access = S_WR_RUN;
            end
            S_WR_RUN: begin
                acc_addr     = ADDR_TCR;
                acc_wdata    = {2'b00, updw_q, 1'b1, 2'b00, cks_q};
                after_access = S_WAIT;
            end
            S_POLL: begin
                acc_write    = 1'b0;
                after_access = (flag_hit || poll_last) ? S_WR_STOP : S_WAIT;
            end
            S_WR_STOP: begin
                acc_addr     = ADDR_TCR;
                acc_wdata    = TCR_STOP;
                after_access = S_CLR_TSR;
            end
            S_CLR_TSR: begin
                after_access = S_DONE;
            end
            default: begin
                is_access = 1'b0;
                acc_write = 1'b0;
            end
        endcase
    end

    // Next-state logic: sequence states plus the bus phase within an access.
    always_comb begin
        state_n = state;
        phase_n = phase;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_WR_TDR;
                    phase_n = PH_SETUP;
                end
            end
            S_WAIT: begin
                if (gap_cnt == 16'd0) begin
                    state_n = S_POLL;
                    phase_n = PH_SETUP;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                case (phase)
                    PH_SETUP:  phase_n = PH_ACCESS;
                    PH_ACCESS: if (pready) phase_n = PH_GAP;
                    default: begin
                        phase_n = PH_SETUP;
                        state_n = after_access;
                    end
                endcase
            end
        endcase
    end

    // APB outputs decoded from state and phase; idle values are all zero.
    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        if (is_access && (phase != PH_GAP)) begin
            psel    = 1'b1;
            penable = (phase == PH_ACCESS);
            pwrite  = acc_write;
            paddr   = acc_addr;
            pwdata  = acc_write ? acc_wdata : 8'h00;
        end
    end

    // State and bus-phase register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= S_IDLE;
            phase <= PH_SETUP;
        end else begin
            state <= state_n;
            phase <= phase_n;
        end
    end

    // Configuration snapshot, taken only when a start is accepted.
    always_ff @(posedge pclk) begin
        if (preset) begin
            tdr_q  <= 8'h00;
            updw_q <= 1'b0;
            cks_q  <= 2'b00;
        end else if (start_acc) begin
            tdr_q  <= cfg_tdr;
            updw_q <= cfg_updw;
            cks_q  <= cfg_cks;
        end
    end

    // Read data is captured in the cycle the slave completes a read.
    always_ff @(posedge pclk) begin
        if (preset) begin
            rd_q <= 8'h00;
        end else if (xfer_done && !acc_write) begin
            rd_q <= prdata;
        end
    end

    // Gap timer between polls: loaded on entry to WAIT, terminal count at zero.
    always_ff @(posedge pclk) begin
        if (preset) begin
            gap_cnt <= 16'd0;
        end else if (enter_wait) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == S_WAIT) && (gap_cnt != 16'd0)) begin
            gap_cnt <= gap_cnt - 16'd1;
        end
    end

    // Poll counter and outcome flags; evaluated once per completed poll.
    always_ff @(posedge pclk) begin
        if (preset) begin
            poll_cnt <= 8'd0;
            flag_ok  <= 1'b0;
            timeout  <= 1'b0;
        end else if (start_acc) begin
            poll_cnt <= 8'd0;
            flag_ok  <= 1'b0;
            timeout  <= 1'b0;
        end else if (poll_step) begin
            if (flag_hit) begin
                flag_ok <= 1'b1;
            end else begin
                poll_cnt <= poll_inc;
                if (poll_last) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

    // Slave errors are sticky until the next accepted start; the sequence
    // itself carries on regardless.
    always_ff @(posedge pclk) begin
        if (preset) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (xfer_done && pslverr) begin
            err_q <= 1'b1;
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign status = {timeout, flag_ok};
    assign err    = err_q;

endmodule
